o_serializer: RTL and testbench



---
 rtl/o_serializer_pkg.sv | 21 ++
 rtl/o_serializer_shifter.sv | 44 ++++
 rtl/o_serializer.sv | 165 ++++++++++++++++
 tb/tb_o_serializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/o_serializer_pkg.sv
// o_serializer_pkg: shared types and constants for the o_serializer output stage.
// Optional feature macro used by the top: O_SERIALIZER_UNDERRUN_CNT_EN.
package o_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam string BIT_ORDER_LSB = "LSB_FIRST";
  localparam string BIT_ORDER_MSB = "MSB_FIRST";

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // Counter width able to hold the value `width` itself (bit_cnt runs 0..WIDTH).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : o_serializer_pkg

// File: rtl/o_serializer_shifter.sv
// o_serializer_shifter: loads a parallel word and presents one bit per shift
// in the selected order. The first bit is taken straight from the load word so
// the top can register it on the load edge; the shift register keeps the rest.
module o_serializer_shifter
  import o_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             first_bit_o,
  output logic             next_bit_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Next shift-register content: remaining bits on load, advance by one on shift.
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = MSB_FIRST ? {word_i[WIDTH-2:0], 1'b0} : {1'b0, word_i[WIDTH-1:1]};
    end else if (shift_i) begin
      shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Shift register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign first_bit_o = MSB_FIRST ? word_i[WIDTH-1] : word_i[0];
  assign next_bit_o  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

endmodule : o_serializer_shifter

// File: rtl/o_serializer.sv
// o_serializer: parallel-to-serial output stage feeding the output buffer.
// Double-buffered (holding register + shifter) so back-to-back words stream
// with no gap bit. OE_OUT is OE_IN delayed one clock to stay aligned with Q.
// Optional feature: define O_SERIALIZER_UNDERRUN_CNT_EN to add a saturating
// 8-bit UNDERRUN_CNT output.
//
// state | meaning
// IDLE  | no word shifting, Q held at IDLE_VALUE; starts a word once one is held
// SHIFT | a word is on Q; bit_cnt counts bits already presented (1..WIDTH)
module o_serializer
  import o_serializer_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter string BIT_ORDER  = "LSB_FIRST",
  parameter logic  IDLE_VALUE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  input  logic             OE_IN,
  output logic             Q,
  output logic             OE_OUT,
  output logic             UNDERRUN
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]       UNDERRUN_CNT
`endif
);

  localparam int CW        = cnt_w(WIDTH);
  localparam bit MSB_FIRST = (BIT_ORDER == BIT_ORDER_MSB);

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $fatal(1, "o_serializer: WIDTH %0d outside legal range", WIDTH);
  end

  if ((BIT_ORDER != BIT_ORDER_LSB) && (BIT_ORDER != BIT_ORDER_MSB)) begin : g_bad_order
    $fatal(1, "o_serializer: illegal BIT_ORDER %s", BIT_ORDER);
  end

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             q_q, q_d;
  logic             oe_q;
  logic             underrun_q, underrun_d;
  logic             accept;
  logic             sh_load, sh_shift;
  logic             sh_first_bit, sh_next_bit;

  // Ready depends only on registered state and RST, never on DATA_VALID.
  assign DATA_READY = !hold_full_q && !RST;
  assign accept     = DATA_VALID && DATA_READY;

  o_serializer_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .word_i     (hold_q),
    .first_bit_o(sh_first_bit),
    .next_bit_o (sh_next_bit)
  );

  // Next-state, holding-register handshake and serial output decode.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    q_d         = q_q;
    underrun_d  = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;

    // Accept only happens with the holding register empty, so it never
    // collides with the FSM draining the holding register below.
    if (accept) begin
      hold_d      = D;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        q_d = IDLE_VALUE;
        if (hold_full_q) begin
          sh_load     = 1'b1;
          q_d         = sh_first_bit;
          bit_cnt_d   = CW'(1);
          hold_full_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CW'(WIDTH)) begin
          if (hold_full_q) begin
            sh_load     = 1'b1;
            q_d         = sh_first_bit;
            bit_cnt_d   = CW'(1);
            hold_full_d = 1'b0;
          end else begin
            q_d        = IDLE_VALUE;
            underrun_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = IDLE;
          end
        end else begin
          sh_shift  = 1'b1;
          q_d       = sh_next_bit;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding register, serial output and OE pipeline registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      q_q         <= IDLE_VALUE;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      q_q         <= q_d;
      oe_q        <= OE_IN;
      underrun_q  <= underrun_d;
    end
  end

  assign Q        = q_q;
  assign OE_OUT   = oe_q;
  assign UNDERRUN = underrun_q;

`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q;

  // Saturating underrun counter, bumped on the same edge the pulse is raised.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ucnt_q <= 8'h00;
    end else if (underrun_d && (ucnt_q != 8'hFF)) begin
      ucnt_q <= ucnt_q + 8'h01;
    end
  end

  assign UNDERRUN_CNT = ucnt_q;
`endif

endmodule : o_serializer

// File: tb/tb_o_serializer.sv
// tb_o_serializer: directed bench for o_serializer. Two instances (LSB_FIRST and
// MSB_FIRST, WIDTH=8) share all inputs; outputs are sampled 1 time unit after
// each rising edge. Define O_SERIALIZER_UNDERRUN_CNT_EN to also cover the counter.
module tb_o_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       dv;
  logic       oe_in;

  logic rdy_l, q_l, oe_l, un_l;
  logic rdy_m, q_m, oe_m, un_m;
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
  logic [7:0] cnt_l, cnt_m;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  o_serializer #(.WIDTH(8), .BIT_ORDER("LSB_FIRST"), .IDLE_VALUE(1'b0)) u_lsb (
    .CLK(clk), .RST(rst), .D(d), .DATA_VALID(dv), .DATA_READY(rdy_l),
    .OE_IN(oe_in), .Q(q_l), .OE_OUT(oe_l), .UNDERRUN(un_l)
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
    , .UNDERRUN_CNT(cnt_l)
`endif
  );

  o_serializer #(.WIDTH(8), .BIT_ORDER("MSB_FIRST"), .IDLE_VALUE(1'b0)) u_msb (
    .CLK(clk), .RST(rst), .D(d), .DATA_VALID(dv), .DATA_READY(rdy_m),
    .OE_IN(oe_in), .Q(q_m), .OE_OUT(oe_m), .UNDERRUN(un_m)
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
    , .UNDERRUN_CNT(cnt_m)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial data and underrun of both instances.
  task automatic chk_out(input string tag, input logic eq_l, input logic eq_m, input logic eun);
    check({tag, "_q_lsb"}, q_l, eq_l);
    check({tag, "_q_msb"}, q_m, eq_m);
    check({tag, "_un_lsb"}, un_l, eun);
    check({tag, "_un_msb"}, un_m, eun);
  endtask

  task automatic chk_rdy(input string tag, input logic er);
    check({tag, "_rdy_lsb"}, rdy_l, er);
    check({tag, "_rdy_msb"}, rdy_m, er);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  seq_a5;
    logic [15:0] exp_l;
    logic [15:0] exp_m;
    logic [7:0]  seq_81;
    logic [9:0]  oe_seq;
    logic        oe_prev;

    seq_a5 = 8'b10100101;              // A5 bit stream, both orders
    exp_m  = 16'b1111000000001111;     // F0,0F MSB first
    exp_l  = 16'b0000111111110000;     // F0,0F LSB first
    seq_81 = 8'b10000001;              // 81 bit stream, both orders
    oe_seq = 10'b0100110100;           // OE_IN per edge, read left to right

    // ---- reset and idle ----
    rst = 1'b1; dv = 1'b0; d = 8'h00; oe_in = 1'b0;
    tick(); tick();
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    check("rst_oe", oe_l, 1'b0);
    chk_rdy("rst", 1'b0);
    rst = 1'b0;
    #1;
    chk_rdy("rst_rel", 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("idle", 1'b0, 1'b0, 1'b0);
      check("idle_oe", {oe_l, oe_m}, 2'b00);
      chk_rdy("idle", 1'b1);
    end

    // ---- single word A5 ----
    d = 8'hA5; dv = 1'b1;
    tick();
    dv = 1'b0;
    chk_rdy("a5_held", 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out("a5_bit", seq_a5[7-k], seq_a5[7-k], 1'b0);
      if (k == 0) chk_rdy("a5_after_load", 1'b1);
    end
    tick();
    chk_out("a5_end", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("a5_idle", 1'b0, 1'b0, 1'b0);
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
    check("cnt_a5", {cnt_l, cnt_m}, 16'h0101);
`endif

    // ---- back-to-back F0, 0F with valid held ----
    d = 8'hF0; dv = 1'b1;
    tick();
    d = 8'h0F;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 1) dv = 1'b0;
      chk_out("b2b_bit", exp_l[15-k], exp_m[15-k], 1'b0);
      if (k == 1) chk_rdy("b2b_held", 1'b0);
      if (k == 8) chk_rdy("b2b_reload", 1'b1);
    end
    tick();
    chk_out("b2b_end", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("b2b_idle", 1'b0, 1'b0, 1'b0);
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
    check("cnt_b2b", {cnt_l, cnt_m}, 16'h0202);
`endif

    // ---- reset mid-word with a word held ----
    d = 8'hFF; dv = 1'b1;
    tick();
    d = 8'h3C;
    tick(); tick();
    dv = 1'b0;
    tick();
    chk_out("rst_mid_pre", 1'b1, 1'b1, 1'b0);
    chk_rdy("rst_mid_pre", 1'b0);
    rst = 1'b1;
    tick();
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0);
`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
    check("cnt_rst", {cnt_l, cnt_m}, 16'h0000);
`endif
    rst = 1'b0;
    #1;
    chk_rdy("rst_mid_rel", 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_out("held_lost", 1'b0, 1'b0, 1'b0);
    end

    // ---- word 81 from bit 0, OE_IN toggling alongside ----
    d = 8'h81; dv = 1'b1;
    oe_prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      oe_in = oe_seq[9-k];
      #1;
      check("oe_hold", {oe_l, oe_m}, {oe_prev, oe_prev});
      tick();
      if (k == 0) dv = 1'b0;
      check("oe_delay", {oe_l, oe_m}, {oe_seq[9-k], oe_seq[9-k]});
      oe_prev = oe_seq[9-k];
      if (k >= 1 && k <= 8) chk_out("w81_bit", seq_81[8-k], seq_81[8-k], 1'b0);
      if (k == 9) chk_out("w81_end", 1'b0, 1'b0, 1'b1);
    end
    oe_in = 1'b0;
    tick();
    chk_out("w81_idle", 1'b0, 1'b0, 1'b0);

`ifdef O_SERIALIZER_UNDERRUN_CNT_EN
    // ---- underrun counter saturation over 300 isolated words ----
    check("cnt_w81", {cnt_l, cnt_m}, 16'h0101);
    for (int n = 1; n <= 300; n++) begin
      logic [7:0] ecnt;
      ecnt = (n + 1 > 255) ? 8'hFF : 8'(n + 1);
      d = 8'h55; dv = 1'b1;
      tick();
      dv = 1'b0;
      repeat (9) tick();
      check("sat_un", {un_l, un_m}, 2'b11);
      tick();
      check("sat_cnt", {cnt_l, cnt_m}, {ecnt, ecnt});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_o_serializer
